// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, register index and the commit controller state.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb  = 4'h3,
    op_jsr  = 4'h4, op_and = 4'h5, op_ldw = 4'h6, op_stw  = 4'h7,
    op_rti  = 4'h8, op_not = 4'h9, op_ldi = 4'ha, op_sti  = 4'hb,
    op_jmp  = 4'hc, op_shf = 4'hd, op_lea = 4'he, op_trap = 4'hf
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {RUN, STORE, FLUSH} commit_state_t;

  function automatic logic is_store(lc3b_opcode op);
    return (op == op_stb) || (op == op_stw);
  endfunction

  function automatic logic writes_reg(lc3b_opcode op);
    return !((op == op_br) || (op == op_stb) || (op == op_stw) || (op == op_jmp));
  endfunction

endpackage

// File: rtl/rob_commit_ctrl.sv
// In-order ROB retirement: register commits pop combinationally, stores wait for mem_resp,
// branch mispredicts redirect the PC and hold flush for FLUSH_CYCLES cycles.
module rob_commit_ctrl
  import lc3b_types::*;
#(
  parameter int TAG_WIDTH    = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic [TAG_WIDTH-1:0] head_tag,
  input  lc3b_opcode           head_inst,
  input  lc3b_reg              head_dest,
  input  logic [15:0]          head_value,
  input  logic [15:0]          head_addr,
  input  logic                 head_predict,
  input  logic                 head_taken,
  output logic                 rob_re,
  output logic                 regfile_we,
  output lc3b_reg              regfile_dest,
  output logic [15:0]          regfile_data,
  output logic [TAG_WIDTH-1:0] regfile_tag,
  output logic                 mem_write,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_wdata,
  output logic                 mem_byte,
  input  logic                 mem_resp,
  output logic                 flush,
  output logic                 pc_redirect_valid,
  output logic [15:0]          pc_redirect,
  output logic [15:0]          commit_cnt,
  output logic [15:0]          mispredict_cnt
);

  commit_state_t state_q, state_d;
  logic [2:0]    flush_cnt_q, flush_cnt_d;
  logic [15:0]   commit_cnt_q, mispredict_cnt_q;
  logic [15:0]   mem_addr_q, mem_wdata_q;
  logic          mem_byte_q;

  logic head_go;
  logic br_miss;
  logic store_start;

  assign head_go     = head_valid && head_ready;
  assign br_miss     = (head_inst == op_br) && (head_predict != head_taken);
  assign store_start = (state_q == RUN) && head_go && is_store(head_inst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (head_go) begin
          if (is_store(head_inst)) begin
            state_d = STORE;
          end else if (br_miss) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_CYCLES[2:0];
          end
        end
      end
      STORE: begin
        if (mem_resp) state_d = RUN;
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    rob_re            = 1'b0;
    regfile_we        = 1'b0;
    pc_redirect_valid = 1'b0;
    mem_write         = 1'b0;
    flush             = 1'b0;
    case (state_q)
      RUN: begin
        if (head_go && !is_store(head_inst)) begin
          rob_re            = 1'b1;
          regfile_we        = writes_reg(head_inst);
          pc_redirect_valid = br_miss;
        end
      end
      STORE: begin
        mem_write = 1'b1;
        rob_re    = mem_resp;
      end
      FLUSH:   flush = 1'b1;
      default: ;
    endcase
  end

  // Store request fields are captured once so a changing head cannot disturb the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= 16'h0;
      mem_wdata_q <= 16'h0;
      mem_byte_q  <= 1'b0;
    end else if (store_start) begin
      mem_addr_q  <= head_addr;
      mem_wdata_q <= head_value;
      mem_byte_q  <= (head_inst == op_stb);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt_q     <= 16'h0;
      mispredict_cnt_q <= 16'h0;
    end else begin
      if (rob_re)            commit_cnt_q     <= commit_cnt_q + 16'd1;
      if (pc_redirect_valid) mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
    end
  end

  assign regfile_dest   = regfile_we ? head_dest  : '0;
  assign regfile_data   = regfile_we ? head_value : 16'h0;
  assign regfile_tag    = regfile_we ? head_tag   : '0;
  assign pc_redirect    = pc_redirect_valid ? head_value : 16'h0;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_byte       = mem_byte_q;
  assign commit_cnt     = commit_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed table, corner sequences, randomized model check.
module tb_rob_commit_ctrl;
  import lc3b_types::*;

  localparam int TW = 3;
  localparam int FC = 2;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          head_valid, head_ready, head_predict, head_taken, mem_resp;
  logic [TW-1:0] head_tag;
  lc3b_opcode    head_inst;
  lc3b_reg       head_dest;
  logic [15:0]   head_value, head_addr;
  logic          rob_re, regfile_we, mem_write, mem_byte, flush, pc_redirect_valid;
  lc3b_reg       regfile_dest;
  logic [15:0]   regfile_data, mem_addr, mem_wdata, pc_redirect, commit_cnt, mispredict_cnt;
  logic [TW-1:0] regfile_tag;

  always #5 clk = ~clk;

  rob_commit_ctrl #(.TAG_WIDTH(TW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .head_valid(head_valid), .head_ready(head_ready), .head_tag(head_tag),
    .head_inst(head_inst), .head_dest(head_dest), .head_value(head_value),
    .head_addr(head_addr), .head_predict(head_predict), .head_taken(head_taken),
    .rob_re(rob_re), .regfile_we(regfile_we), .regfile_dest(regfile_dest),
    .regfile_data(regfile_data), .regfile_tag(regfile_tag),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte(mem_byte), .mem_resp(mem_resp), .flush(flush),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
    .commit_cnt(commit_cnt), .mispredict_cnt(mispredict_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_commit = 0;
  int exp_mis = 0;

  typedef struct {
    logic       v, r;
    lc3b_opcode op;
    lc3b_reg    dest;
    logic [15:0] val;
    logic [2:0] tag;
    logic       pred, tkn;
    logic       e_re, e_we;
  } vec_t;
  vec_t tbl[11];

  function automatic vec_t mk(logic v, logic r, lc3b_opcode op, lc3b_reg d, logic [15:0] val,
                              logic [2:0] t, logic p, logic k, logic er, logic ew);
    vec_t x;
    x.v = v; x.r = r; x.op = op; x.dest = d; x.val = val; x.tag = t;
    x.pred = p; x.tkn = k; x.e_re = er; x.e_we = ew;
    return x;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    head_valid = 0; head_ready = 0; head_inst = op_add; head_dest = '0;
    head_value = '0; head_addr = '0; head_tag = '0; head_predict = 0; head_taken = 0;
    mem_resp = 0;
  endtask

  task automatic set_head(input lc3b_opcode op, input lc3b_reg d, input logic [15:0] v,
                          input logic [TW-1:0] t, input logic p, input logic k);
    head_valid = 1; head_ready = 1; head_inst = op; head_dest = d;
    head_value = v; head_tag = t; head_predict = p; head_taken = k;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    cyc();
    exp_commit = 0;
    exp_mis = 0;
  endtask

  // Store with memory answering after lat cycles; the head is scrambled once the store is registered.
  task automatic store_seq(input lc3b_opcode op, input logic [15:0] a, input logic [15:0] d,
                           input int lat);
    set_head(op, 3'd0, d, 3'd1, 0, 0);
    head_addr = a;
    #1;
    chk("store_run_mem_write", {15'h0, mem_write}, 16'h0);
    chk("store_run_rob_re", {15'h0, rob_re}, 16'h0);
    cyc();
    head_addr = 16'hdead; head_value = 16'h0; head_inst = op_add; head_valid = 0;
    for (int i = 0; i <= lat; i++) begin
      mem_resp = (i == lat);
      #1;
      chk("store_mem_write", {15'h0, mem_write}, 16'h1);
      chk("store_addr", mem_addr, a);
      chk("store_wdata", mem_wdata, d);
      chk("store_byte", {15'h0, mem_byte}, {15'h0, op == op_stb});
      chk("store_rob_re", {15'h0, rob_re}, {15'h0, i == lat});
      chk("store_no_we", {15'h0, regfile_we}, 16'h0);
      cyc();
    end
    exp_commit++;
    mem_resp = 0;
    chk("store_commit_cnt", commit_cnt, exp_commit[15:0]);
  endtask

  logic m_busy, m_byte;
  logic [15:0] m_addr, m_data;
  int m_flush_left, m_commit, m_mis;
  logic e_re, e_we, e_mw, e_fl, e_rv;

  initial begin
    rst_n = 0;
    idle();
    #2;
    chk("rst_rob_re", {15'h0, rob_re}, 16'h0);
    chk("rst_mem_write", {15'h0, mem_write}, 16'h0);
    chk("rst_flush", {15'h0, flush}, 16'h0);
    chk("rst_redirect", {15'h0, pc_redirect_valid}, 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_commit_cnt", commit_cnt, 16'h0);
    chk("rst_mis_cnt", mispredict_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1;
    cyc();

    set_head(op_add, 3'd3, 16'h1234, 3'd2, 0, 0);
    #1;
    chk("add_rob_re", {15'h0, rob_re}, 16'h1);
    chk("add_we", {15'h0, regfile_we}, 16'h1);
    chk("add_dest", {13'h0, regfile_dest}, 16'h3);
    chk("add_data", regfile_data, 16'h1234);
    chk("add_tag", {13'h0, regfile_tag}, 16'h2);
    cyc();
    exp_commit++;
    idle();
    chk("add_commit_cnt", commit_cnt, exp_commit[15:0]);

    set_head(op_add, 3'd1, 16'h5555, 3'd3, 0, 0);
    head_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rob_re", {15'h0, rob_re}, 16'h0);
      cyc();
    end
    head_ready = 1;
    #1;
    chk("stall_release_rob_re", {15'h0, rob_re}, 16'h1);
    cyc();
    exp_commit++;
    idle();
    #1;
    chk("stall_single_pop", commit_cnt, exp_commit[15:0]);

    store_seq(op_stw, 16'h3000, 16'hbeef, 3);
    store_seq(op_stb, 16'h3001, 16'h00a5, 1);
    store_seq(op_stw, 16'h4002, 16'h1357, 0);
    idle();
    #1;
    chk("store_done_mem_write", {15'h0, mem_write}, 16'h0);

    set_head(op_br, 3'd0, 16'h0040, 3'd4, 0, 1);
    #1;
    chk("miss_rob_re", {15'h0, rob_re}, 16'h1);
    chk("miss_redirect_vld", {15'h0, pc_redirect_valid}, 16'h1);
    chk("miss_redirect", pc_redirect, 16'h0040);
    chk("miss_no_we", {15'h0, regfile_we}, 16'h0);
    cyc();
    exp_commit++;
    exp_mis++;
    for (int i = 0; i < FC; i++) begin
      #1;
      chk("flush_on", {15'h0, flush}, 16'h1);
      chk("flush_no_pop", {15'h0, rob_re}, 16'h0);
      chk("flush_no_redirect", {15'h0, pc_redirect_valid}, 16'h0);
      cyc();
    end
    set_head(op_br, 3'd0, 16'h0080, 3'd5, 1, 1);
    #1;
    chk("flush_off", {15'h0, flush}, 16'h0);
    chk("hit_rob_re", {15'h0, rob_re}, 16'h1);
    chk("hit_no_redirect", {15'h0, pc_redirect_valid}, 16'h0);
    chk("mis_cnt", mispredict_cnt, exp_mis[15:0]);
    cyc();
    exp_commit++;
    idle();
    #1;
    chk("hit_no_flush", {15'h0, flush}, 16'h0);
    chk("branch_commit_cnt", commit_cnt, exp_commit[15:0]);

    tbl[0]  = mk(H, H, op_add, 3'd1, 16'h1111, 3'd0, L, L, H, H);
    tbl[1]  = mk(H, L, op_and, 3'd2, 16'h2222, 3'd1, L, L, L, L);
    tbl[2]  = mk(L, H, op_ldw, 3'd3, 16'h3333, 3'd2, L, L, L, L);
    tbl[3]  = mk(H, H, op_jmp, 3'd4, 16'h4444, 3'd3, L, L, H, L);
    tbl[4]  = mk(H, H, op_br,  3'd5, 16'h5555, 3'd4, H, H, H, L);
    tbl[5]  = mk(H, H, op_br,  3'd6, 16'h6666, 3'd5, L, L, H, L);
    tbl[6]  = mk(H, H, op_lea, 3'd7, 16'h7777, 3'd6, L, L, H, H);
    tbl[7]  = mk(H, H, op_jsr, 3'd7, 16'h8888, 3'd7, L, H, H, H);
    tbl[8]  = mk(H, H, op_trap, 3'd7, 16'h9999, 3'd0, L, L, H, H);
    tbl[9]  = mk(L, L, op_shf, 3'd1, 16'haaaa, 3'd1, L, L, L, L);
    tbl[10] = mk(H, H, op_not, 3'd0, 16'hbbbb, 3'd2, H, L, H, H);
    for (int i = 0; i < 11; i++) begin
      set_head(tbl[i].op, tbl[i].dest, tbl[i].val, tbl[i].tag, tbl[i].pred, tbl[i].tkn);
      head_valid = tbl[i].v;
      head_ready = tbl[i].r;
      #1;
      chk("tbl_rob_re", {15'h0, rob_re}, {15'h0, tbl[i].e_re});
      chk("tbl_we", {15'h0, regfile_we}, {15'h0, tbl[i].e_we});
      if (tbl[i].e_we) begin
        chk("tbl_dest", {13'h0, regfile_dest}, {13'h0, tbl[i].dest});
        chk("tbl_data", regfile_data, tbl[i].val);
        chk("tbl_tag", {13'h0, regfile_tag}, {13'h0, tbl[i].tag});
      end
      chk("tbl_no_flush", {15'h0, flush}, 16'h0);
      chk("tbl_no_mem_write", {15'h0, mem_write}, 16'h0);
      cyc();
      if (tbl[i].e_re) exp_commit++;
    end
    idle();
    chk("tbl_commit_cnt", commit_cnt, exp_commit[15:0]);

    do_reset();
    m_busy = 0; m_byte = 0; m_addr = '0; m_data = '0;
    m_flush_left = 0; m_commit = 0; m_mis = 0;
    for (int n = 0; n < 3000; n++) begin
      head_valid   = ($urandom_range(0, 3) != 0);
      head_ready   = ($urandom_range(0, 3) != 0);
      head_inst    = lc3b_opcode'(4'($urandom_range(0, 15)));
      head_dest    = 3'($urandom);
      head_value   = 16'($urandom);
      head_addr    = 16'($urandom);
      head_tag     = 3'($urandom);
      head_predict = 1'($urandom);
      head_taken   = 1'($urandom);
      mem_resp     = ($urandom_range(0, 2) == 0);
      e_re = 0; e_we = 0; e_mw = 0; e_fl = 0; e_rv = 0;
      if (m_flush_left > 0) begin
        e_fl = 1;
        m_flush_left--;
      end else if (m_busy) begin
        e_mw = 1;
        if (mem_resp) begin
          e_re = 1; m_busy = 0; m_commit++;
        end
      end else if (head_valid && head_ready) begin
        if (head_inst == op_stb || head_inst == op_stw) begin
          m_busy = 1; m_addr = head_addr; m_data = head_value; m_byte = (head_inst == op_stb);
        end else begin
          e_re = 1;
          m_commit++;
          if (head_inst == op_br && head_predict != head_taken) begin
            e_rv = 1; m_mis++; m_flush_left = FC;
          end else if (head_inst != op_br && head_inst != op_jmp) begin
            e_we = 1;
          end
        end
      end
      #1;
      chk("rnd_rob_re", {15'h0, rob_re}, {15'h0, e_re});
      chk("rnd_we", {15'h0, regfile_we}, {15'h0, e_we});
      chk("rnd_mem_write", {15'h0, mem_write}, {15'h0, e_mw});
      chk("rnd_flush", {15'h0, flush}, {15'h0, e_fl});
      chk("rnd_redirect_vld", {15'h0, pc_redirect_valid}, {15'h0, e_rv});
      if (e_we) begin
        chk("rnd_dest", {13'h0, regfile_dest}, {13'h0, head_dest});
        chk("rnd_data", regfile_data, head_value);
        chk("rnd_tag", {13'h0, regfile_tag}, {13'h0, head_tag});
      end
      if (e_mw) begin
        chk("rnd_addr", mem_addr, m_addr);
        chk("rnd_wdata", mem_wdata, m_data);
        chk("rnd_byte", {15'h0, mem_byte}, {15'h0, m_byte});
      end
      if (e_rv) chk("rnd_redirect", pc_redirect, head_value);
      cyc();
      chk("rnd_commit_cnt", commit_cnt, m_commit[15:0]);
      chk("rnd_mis_cnt", mispredict_cnt, m_mis[15:0]);
    end

    idle();
    mem_resp = 1;
    repeat (4) cyc();
    mem_resp = 0;
    set_head(op_stw, 3'd0, 16'hcafe, 3'd1, 0, 0);
    head_addr = 16'h5000;
    cyc();
    #1;
    chk("midstore_mem_write", {15'h0, mem_write}, 16'h1);
    #1;
    rst_n = 0;
    #1;
    chk("midstore_rst_mem_write", {15'h0, mem_write}, 16'h0);
    chk("midstore_rst_commit", commit_cnt, 16'h0);
    chk("midstore_rst_mis", mispredict_cnt, 16'h0);
    set_head(op_add, 3'd2, 16'h0001, 3'd0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("post_rst_run_pop", {15'h0, rob_re}, 16'h1);
    chk("post_rst_mem_write", {15'h0, mem_write}, 16'h0);

    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", commit_cnt, 16'hffff);
    cyc();
    chk("wrap_zero", commit_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
